// File: rtl/delay_sched.sv
// delay_sched: shared delay-timer scheduler granting one CBITS counter to NREQ requesters
// Ports: clk, rst (async, active-high); req[NREQ] level requests; len[NREQ*CBITS] per-requester
// lengths (0 selects N); gnt one-hot grant while timing; done one-cycle completion to the winner;
// sig OR of done; busy timer occupied; flg idle and ready; err sticky invariant violation.
// Build option: DELAY_SCHED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module delay_sched #(
    parameter int NREQ  = 4,
    parameter int CBITS = 15,
    parameter int N     = 20000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CBITS-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  sig,
    output logic                  busy,
    output logic                  flg,
    output logic                  err
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [CBITS-1:0] cnt, tgt, ln;
    logic [PW-1:0] w, wi;
    logic hit, bad;
`ifndef DELAY_SCHED_PRIO_EN
    logic [PW-1:0] ptr;
`endif
    // Descending scan so the last hit written is the one closest to the search start
    always_comb begin
        hit = 1'b0;
        w = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef DELAY_SCHED_PRIO_EN
            if (req[k]) begin
                hit = 1'b1;
                w = PW'(k);
            end
`else
            if (req[(int'(ptr) + k) % NREQ]) begin
                hit = 1'b1;
                w = PW'((int'(ptr) + k) % NREQ);
            end
`endif
        end
    end
    assign ln = len[int'(w)*CBITS +: CBITS];
    assign bad = (|(gnt & (gnt - NREQ'(1)))) | (|(done & (done - NREQ'(1)))) |
                 ((|gnt) & (|done)) | ((state == RUN) && (cnt > tgt));
    assign flg = (state == IDLE);
    assign busy = (state != IDLE);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            tgt <= '0;
            wi <= '0;
            gnt <= '0;
            done <= '0;
            sig <= 1'b0;
            err <= 1'b0;
`ifndef DELAY_SCHED_PRIO_EN
            ptr <= '0;
`endif
        end else begin
            done <= '0;
            sig <= 1'b0;
            if (bad) err <= 1'b1;
            case (state)
                IDLE: if (hit) begin
                    wi <= w;
                    tgt <= (ln == '0) ? CBITS'(N) : ln;
                    cnt <= CBITS'(1);
                    gnt <= NREQ'(1) << w;
`ifndef DELAY_SCHED_PRIO_EN
                    ptr <= (w == PW'(NREQ - 1)) ? '0 : w + PW'(1);
`endif
                    state <= RUN;
                end
                // Abandon outranks expiry, so a dropped request never sees done
                RUN: if (!req[wi]) begin
                    gnt <= '0;
                    state <= IDLE;
                end else if (cnt == tgt) begin
                    gnt <= '0;
                    done <= NREQ'(1) << wi;
                    sig <= 1'b1;
                    state <= DONE;
                end else begin
                    cnt <= cnt + CBITS'(1);
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_delay_sched.sv
// tb_delay_sched: directed vector bench for delay_sched with default parameters
module tb_delay_sched;
    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] req = '0;
    logic [59:0] len = '0;
    logic [3:0] gnt, done;
    logic sig, busy, flg, err;
    int ncmp = 0, nfail = 0;

    delay_sched dut (.clk(clk), .rst(rst), .req(req), .len(len), .gnt(gnt), .done(done),
                     .sig(sig), .busy(busy), .flg(flg), .err(err));

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        logic [14:0] ln;
        int exp;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
        step();
    endtask

    // Waits for any grant; n is the number of edges taken, w the granted index (-1 if none)
    task automatic await_gnt(output int w, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (gnt == 0 && n < 10);
        w = -1;
        for (int i = 0; i < 4; i++) if (gnt[i]) w = i;
    endtask

    // Counts consecutive samples with gnt equal to oh, bounded
    task automatic count_gnt(input logic [3:0] oh, input int bound, output int n);
        n = 0;
        while (gnt == oh && n < bound) begin
            n++;
            step();
        end
    endtask

    vec_t vt[6];
    int n, w, g;
    logic [3:0] oh;
    int exp_order[5];
    bit saw_done;

    initial begin
        vt[0] = '{0, 15'd5, 5};
        vt[1] = '{1, 15'd1, 1};
        vt[2] = '{2, 15'd3, 3};
        vt[3] = '{3, 15'd7, 7};
        vt[4] = '{2, 15'd0, 20000};
        vt[5] = '{1, 15'd2, 2};
`ifdef DELAY_SCHED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        #1;
        chk("reset_gnt", int'(gnt), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_sig", int'(sig), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_flg", int'(flg), 1);
        chk("reset_err", int'(err), 0);
        step();
        rst = 1'b0;
        step();

        for (int v = 0; v < 6; v++) begin
            oh = 4'b0001 << vt[v].idx;
            len[vt[v].idx*15 +: 15] = vt[v].ln;
            req = oh;
            step();
            count_gnt(oh, vt[v].exp + 5, n);
            chk($sformatf("vec%0d_gnt_cycles", v), n, vt[v].exp);
            chk($sformatf("vec%0d_done", v), int'(done), int'(oh));
            chk($sformatf("vec%0d_sig", v), int'(sig), 1);
            chk($sformatf("vec%0d_busy", v), int'(busy), 1);
            req = '0;
            step();
            chk($sformatf("vec%0d_flg", v), int'(flg), 1);
            chk($sformatf("vec%0d_done_clr", v), int'(done), 0);
            chk($sformatf("vec%0d_err", v), int'(err), 0);
        end

        do_reset();
        len = {4{15'd2}};
        req = 4'b1111;
        for (g = 0; g < 5; g++) begin
            await_gnt(w, n);
            chk($sformatf("contend_order%0d", g), w, exp_order[g]);
            chk($sformatf("contend_gap%0d", g), n, (g == 0) ? 1 : 2);
            oh = gnt;
            count_gnt(oh, 10, n);
            chk($sformatf("contend_len%0d", g), n, 2);
            chk($sformatf("contend_done%0d", g), int'(done), int'(oh));
        end
        req = '0;
        step();
        step();

        len[15 +: 15] = 15'd10;
        req = 4'b0010;
        step();
        step();
        step();
        chk("abandon_gnt3", int'(gnt), 2);
        req = '0;
        step();
        chk("abandon_gnt", int'(gnt), 0);
        chk("abandon_flg", int'(flg), 1);
        saw_done = (done != 0) || sig;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done != 0 || sig) saw_done = 1'b1;
        end
        chk("abandon_no_done", int'(saw_done), 0);

        len[0 +: 15] = 15'd10;
        req = 4'b0001;
        for (int i = 0; i < 4; i++) step();
        chk("rstmid_gnt_before", int'(gnt), 1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_gnt", int'(gnt), 0);
        chk("rstmid_done", int'(done), 0);
        chk("rstmid_sig", int'(sig), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_flg", int'(flg), 1);
        req = '0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("rstmid_idle", int'(flg), 1);
        chk("rstmid_err", int'(err), 0);

        len[0 +: 15] = 15'd5;
        req = 4'b0001;
        step();
        len[0 +: 15] = 15'd1;
        count_gnt(4'b0001, 20, n);
        chk("lenchg_gnt_cycles", n, 5);
        chk("lenchg_done", int'(done), 1);
        req = '0;
        step();
        chk("final_err", int'(err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
